// File: rtl/mod10_sched_if.sv
// Request/grant and result handshake bundle for the shared divide-by-10 scheduler.
interface mod10_sched_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       gnt;
    logic                   busy;
    logic                   res_valid;
    logic                   res_ready;
    logic [WIDTH-1:0]       res_quot;
    logic [3:0]             res_rem;
    logic [ID_W-1:0]        res_id;

    // Requesters and result consumer
    modport master (
        output req, req_data, res_ready,
        input  gnt, busy, res_valid, res_quot, res_rem, res_id
    );

    // Scheduler side
    modport slave (
        input  req, req_data, res_ready,
        output gnt, busy, res_valid, res_quot, res_rem, res_id
    );
endinterface

// File: rtl/mod10_sched.sv
// Round-robin scheduler feeding one iterative subtract-10 divider; returns
// quotient, remainder and owner id over a valid/ready handshake.
module mod10_sched #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic         clock,
    input  logic         resetn,
    mod10_sched_if.slave bus
);
    localparam int unsigned     ID_W = $clog2(N_REQ);
    localparam logic [WIDTH-1:0] TEN = WIDTH'(10);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_busy;
    logic [ID_W-1:0]  r_ptr;
    logic [ID_W-1:0]  r_id;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] r_quot;
    logic             r_res_valid;
    logic [WIDTH-1:0] r_res_quot;
    logic [3:0]       r_res_rem;
    logic [ID_W-1:0]  r_res_id;

    logic             w_found;
    logic [ID_W-1:0]  w_winner;
    logic [ID_W-1:0]  w_idx;
    logic [ID_W-1:0]  w_ptr_nxt;
    logic [WIDTH-1:0] w_operand;
    logic [N_REQ-1:0] w_gnt;
    logic             w_grant;
    logic             w_ge10;
    logic             w_handshake;

    // First set request scanning upward from the pointer, with wrap
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            w_idx = ID_W'((32'(r_ptr) + k) % N_REQ);
            if (!w_found && bus.req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // Operand of the winning requester
    always_comb begin
        w_operand = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (w_winner == ID_W'(k)) begin
                w_operand = bus.req_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign w_ptr_nxt   = (32'(w_winner) == N_REQ - 1) ? '0 : w_winner + ID_W'(1);
    assign w_ge10      = (r_work >= TEN);
    assign w_handshake = r_res_valid & bus.res_ready;

    // Next-state and grant decode; grant only from IDLE and never in reset
    always_comb begin
        w_state_nxt = r_state;
        w_gnt       = '0;
        w_grant     = 1'b0;
        case (r_state)
            IDLE: begin
                if (resetn && w_found) begin
                    w_gnt       = N_REQ'(1) << w_winner;
                    w_grant     = 1'b1;
                    w_state_nxt = CALC;
                end
            end
            CALC: begin
                if (!w_ge10) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (w_handshake) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register and busy flag
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != IDLE);
        end
    end

    // Operand load on grant, subtract loop, result capture and release
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_ptr       <= '0;
            r_id        <= '0;
            r_work      <= '0;
            r_quot      <= '0;
            r_res_valid <= 1'b0;
            r_res_quot  <= '0;
            r_res_rem   <= '0;
            r_res_id    <= '0;
        end else begin
            if (w_grant) begin
                r_work <= w_operand;
                r_quot <= '0;
                r_id   <= w_winner;
                r_ptr  <= w_ptr_nxt;
            end
            if (r_state == CALC) begin
                if (w_ge10) begin
                    r_work <= r_work - TEN;
                    r_quot <= r_quot + WIDTH'(1);
                end else begin
                    r_res_valid <= 1'b1;
                    r_res_quot  <= r_quot;
                    r_res_rem   <= r_work[3:0];
                    r_res_id    <= r_id;
                end
            end
            if ((r_state == DONE) && w_handshake) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign bus.gnt       = w_gnt;
    assign bus.busy      = r_busy;
    assign bus.res_valid = r_res_valid;
    assign bus.res_quot  = r_res_quot;
    assign bus.res_rem   = r_res_rem;
    assign bus.res_id    = r_res_id;
endmodule
